// File: rtl/dcm_prog_pkg.sv
// Shared types and constants for the DCM_CLKGEN M/D reprogramming controller.
// Commands go out LSB first as {value[7:0], cmd[1:0]}.
package dcm_prog_pkg;

    typedef enum logic [3:0] {
        INIT,
        IDLE,
        LOAD_D,
        GAP1,
        LOAD_M,
        GAP2,
        GO,
        WAIT_DONE,
        WAIT_LOCK
    } state_e;

    localparam logic [1:0] CMD_LOADD = 2'b01;
    localparam logic [1:0] CMD_LOADM = 2'b11;
    localparam logic [3:0] SHIFT_LEN = 4'd10;

    function automatic logic [9:0] cmd_word(input logic [7:0] val,
                                            input logic [1:0] cmd);
        return {val, cmd};
    endfunction

endpackage

// File: rtl/dcm_clkgen_prog.sv
// DCM_CLKGEN serial M/D reprogramming: LoadD, LoadM, Go, then wait for
// PROGDONE and LOCKED before re-enabling the BUFGCE of the generated clock.
module dcm_clkgen_prog
    import dcm_prog_pkg::*;
#(
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] m_minus1_i,
    input  logic [7:0] d_minus1_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic       progen_o,
    output logic       progdata_o,
    input  logic       progdone_i,
    input  logic       locked_i,
    output logic       ce_o
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [9:0]  sh_q, sh_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] tmo_q, tmo_d;
    logic [7:0]  m_q, m_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        progen_q, progen_d;
    logic        progdata_q, progdata_d;
    logic        ce_q, ce_d;
    logic [9:0]  word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            sh_q       <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            m_q        <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            progen_q   <= 1'b0;
            progdata_q <= 1'b0;
            ce_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            m_q        <= m_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            progen_q   <= progen_d;
            progdata_q <= progdata_d;
            ce_q       <= ce_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        m_d        = m_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        progen_d   = 1'b0;
        progdata_d = 1'b0;
        ce_d       = ce_q;
        word       = '0;
        unique case (state_q)
            INIT: begin
                if (locked_i) begin
                    ce_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (ce_q && !locked_i) begin
                    ce_d    = 1'b0;
                    state_d = INIT;
                end else if (start_i) begin
                    if (m_minus1_i == 8'd0) begin
                        err_d = 1'b1;
                    end else begin
                        word       = cmd_word(d_minus1_i, CMD_LOADD);
                        m_d        = m_minus1_i;
                        ce_d       = 1'b0;
                        progen_d   = 1'b1;
                        progdata_d = word[0];
                        sh_d       = word >> 1;
                        cnt_d      = 4'd1;
                        state_d    = LOAD_D;
                    end
                end
            end
            LOAD_D, LOAD_M: begin
                if (cnt_q == SHIFT_LEN) begin
                    state_d = (state_q == LOAD_D) ? GAP1 : GAP2;
                end else begin
                    progen_d   = 1'b1;
                    progdata_d = sh_q[0];
                    sh_d       = sh_q >> 1;
                    cnt_d      = cnt_q + 4'd1;
                end
            end
            GAP1: begin
                word       = cmd_word(m_q, CMD_LOADM);
                progen_d   = 1'b1;
                progdata_d = word[0];
                sh_d       = word >> 1;
                cnt_d      = 4'd1;
                state_d    = LOAD_M;
            end
            GAP2: begin
                progen_d = 1'b1;
                state_d  = GO;
            end
            GO: begin
                tmo_d   = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE, WAIT_LOCK: begin
                tmo_d = tmo_q + 16'd1;
                // PROGDONE is stale for two cycles after Go
                if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (state_q == WAIT_DONE) begin
                    if (progdone_i && tmo_q >= 16'd2) state_d = WAIT_LOCK;
                end else if (locked_i) begin
                    ce_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign progen_o   = progen_q;
    assign progdata_o = progdata_q;
    assign ce_o       = ce_q;

endmodule

// File: tb/tb_dcm_clkgen_prog.sv
// Scoreboard bench for dcm_clkgen_prog: expected PROGEN bits and DONE/ERR
// pulses are queued with their cycle numbers and checked by a monitor.
module tb_dcm_clkgen_prog;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] m_i = '0;
    logic [7:0] d_i = '0;
    logic       busy_o, done_o, err_o, progen_o, progdata_o, ce_o;
    logic       progdone_i = 1'b0;
    logic       locked_i = 1'b0;

    dcm_clkgen_prog #(.TIMEOUT(100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .m_minus1_i (m_i),
        .d_minus1_i (d_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .progen_o   (progen_o),
        .progdata_o (progdata_o),
        .progdone_i (progdone_i),
        .locked_i   (locked_i),
        .ce_o       (ce_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = PROGEN-high bit, 1 = DONE pulse, 2 = ERR pulse
    typedef struct {
        int   kind;
        int   cyc;
        logic dat;
    } ev_t;

    ev_t q[$];
    int  total = 0;
    int  bad = 0;

    task automatic exp_ev(input int k, input int c, input logic d);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.dat  = d;
        q.push_back(e);
    endtask

    task automatic exp_burst(input int c0, input logic [7:0] v,
                             input logic [1:0] cmd, input int nb);
        logic [9:0] s;
        s = {v, cmd};
        for (int i = 0; i < nb; i++) exp_ev(0, c0 + i, s[i]);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                     nm, cyc, act, req);
        end
    endtask

    task automatic at(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic go(input logic [7:0] m, input logic [7:0] d,
                      input int mb, output int e);
        @(negedge clk);
        e = cyc + 1;
        if (m == 8'd0) begin
            exp_ev(2, e, 1'b0);
        end else begin
            exp_burst(e, d, 2'b01, 10);
            exp_burst(e + 11, m, 2'b11, mb);
            if (mb == 10) exp_ev(0, e + 22, 1'b0);
        end
        m_i = m;
        d_i = d;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    ev_t mev;
    int  mkind;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && (progen_o || done_o || err_o)) begin
                mkind = progen_o ? 0 : (done_o ? 1 : 2);
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event cyc=%0d kind=%0d", cyc, mkind);
                end else begin
                    mev = q.pop_front();
                    if (mev.kind != mkind || mev.cyc != cyc ||
                        (mkind == 0 && progdata_o !== mev.dat)) begin
                        bad++;
                        $display("FAIL event actual kind=%0d cyc=%0d dat=%b required kind=%0d cyc=%0d dat=%b",
                                 mkind, cyc, progdata_o, mev.kind, mev.cyc, mev.dat);
                    end
                end
            end
        end
    end

    int e;
    initial begin
        at(1);
        chk("reset_values", {busy_o, done_o, err_o, progen_o, progdata_o, ce_o},
            32'b100000);
        at(2);
        rst_n = 1'b1;
        at(4);
        locked_i = 1'b1;
        at(4 + 3);
        chk("init_ce", ce_o, 1'b1);
        chk("init_busy", busy_o, 1'b0);

        // Normal sequence M=0x22 D=0x07 with a DCM that relocks later
        go(8'h22, 8'h07, 10, e);
        locked_i = 1'b0;
        chk("seq_ce_low", ce_o, 1'b0);
        chk("seq_busy", busy_o, 1'b1);
        at(e + 30);
        progdone_i = 1'b1;
        at(e + 31);
        progdone_i = 1'b0;
        exp_ev(1, e + 82, 1'b0);
        at(e + 60);
        chk("wait_lock_ce_low", ce_o, 1'b0);
        at(e + 81);
        locked_i = 1'b1;
        at(e + 82);
        chk("done_ce", ce_o, 1'b1);
        chk("done_idle", busy_o, 1'b0);

        // Invalid M rejected
        go(8'h00, 8'h55, 10, e);
        chk("bad_m_busy", busy_o, 1'b0);
        chk("bad_m_ce", ce_o, 1'b1);
        at(e + 2);
        chk("bad_m_busy2", busy_o, 1'b0);

        // START during LoadM ignored, then PROGDONE never comes
        go(8'hA5, 8'h3C, 10, e);
        locked_i = 1'b0;
        at(e + 13);
        m_i = 8'h11;
        d_i = 8'h22;
        start_i = 1'b1;
        at(e + 14);
        start_i = 1'b0;
        exp_ev(2, e + 123, 1'b0);
        at(e + 122);
        chk("tmo_busy", busy_o, 1'b1);
        at(e + 124);
        chk("tmo_ce_low", ce_o, 1'b0);
        chk("tmo_idle", busy_o, 1'b0);

        // Following valid sequence restores CE
        go(8'h01, 8'h00, 10, e);
        at(e + 30);
        progdone_i = 1'b1;
        at(e + 31);
        progdone_i = 1'b0;
        exp_ev(1, e + 41, 1'b0);
        at(e + 40);
        locked_i = 1'b1;
        at(e + 41);
        chk("recover_ce", ce_o, 1'b1);

        // Reset at the 5th LoadM bit
        go(8'h22, 8'h07, 5, e);
        locked_i = 1'b0;
        at(e + 15);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_progen", progen_o, 1'b0);
        chk("rst_ce", ce_o, 1'b0);
        chk("rst_busy", busy_o, 1'b1);
        at(e + 18);
        locked_i = 1'b1;
        rst_n = 1'b1;
        at(e + 21);
        chk("rst_relock_busy", busy_o, 1'b0);
        chk("rst_relock_ce", ce_o, 1'b1);

        at(e + 25);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
